// File: rtl/cpu65xx_status_reg_pkg.sv
// Shared 65xx microcode constants: flag bit positions in P and setClrOp encodings.
// Used by the status register, the ALU and the microcode ROM generator.
package cpu65xx_status_reg_pkg;

    localparam int C_BIT_IN_P = 0;
    localparam int Z_BIT_IN_P = 1;
    localparam int I_BIT_IN_P = 2;
    localparam int D_BIT_IN_P = 3;
    localparam int B_BIT_IN_P = 4;
    localparam int V_BIT_IN_P = 6;
    localparam int N_BIT_IN_P = 7;

    typedef enum logic [2:0] {
        SC_NONE = 3'd0,
        SC_SEC  = 3'd1,
        SC_CLC  = 3'd2,
        SC_SED  = 3'd3,
        SC_CLD  = 3'd4,
        SC_SEI  = 3'd5,
        SC_CLI  = 3'd6,
        SC_CLV  = 3'd7
    } set_clr_op_e;

    // Bit 5 always reads as 1; B only exists in the pushed copy.
    function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                          input logic d, input logic i, input logic z,
                                          input logic c);
        return {n, v, 1'b1, b, d, i, z, c};
    endfunction

endpackage

// File: rtl/cpu65xx_status_reg_if.sv
// Flag interface between ALU/microcode (master) and the status register (slave).
// Carries ALU flag results, microcode controls and the P views fed back to the core.
interface cpu65xx_status_reg_if;
    logic       aluCarry;
    logic       aluZero;
    logic       aluNegative;
    logic       aluOverflow;
    logic [3:0] flagWrite;
    logic [2:0] setClrOp;
    logic       loadP;
    logic       loadIsRti;
    logic [7:0] dataIn;
    logic       interruptEntry;
    logic       pushIsBrk;
    logic       instrBoundary;
    logic [7:0] pFlags;
    logic [7:0] pushValue;
    logic       carryFlag;
    logic       overflowFlag;
    logic       decimalFlag;
    logic       irqMask;

    modport master (
        output aluCarry, aluZero, aluNegative, aluOverflow, flagWrite, setClrOp,
               loadP, loadIsRti, dataIn, interruptEntry, pushIsBrk, instrBoundary,
        input  pFlags, pushValue, carryFlag, overflowFlag, decimalFlag, irqMask
    );

    modport slave (
        input  aluCarry, aluZero, aluNegative, aluOverflow, flagWrite, setClrOp,
               loadP, loadIsRti, dataIn, interruptEntry, pushIsBrk, instrBoundary,
        output pFlags, pushValue, carryFlag, overflowFlag, decimalFlag, irqMask
    );
endinterface

// File: rtl/cpu65xx_imask_delay.sv
// Effective IRQ mask: I reaches irqMask through iStage at instruction boundaries,
// or in the same edge on an immediate write (RTI, interrupt entry) or when DELAY_I=0.
module cpu65xx_imask_delay #(
    parameter bit DELAY_I = 1'b1,
    parameter bit RESET_I = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_next,
    input  logic i_imm_wr,
    input  logic instr_boundary,
    output logic irq_mask
);

    logic i_stage_q, i_stage_d;
    logic irq_mask_q, irq_mask_d;

    always_comb begin
        i_stage_d  = i_stage_q;
        irq_mask_d = irq_mask_q;
        if (!DELAY_I || i_imm_wr) begin
            i_stage_d  = i_next;
            irq_mask_d = i_next;
        end else if (instr_boundary) begin
            // iStage samples I after this edge's update, so a coincident SEI/CLI lands here
            irq_mask_d = i_stage_q;
            i_stage_d  = i_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_stage_q  <= RESET_I;
            irq_mask_q <= RESET_I;
        end else begin
            i_stage_q  <= i_stage_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign irq_mask = irq_mask_q;

endmodule

// File: rtl/cpu65xx_status_reg.sv
// 65xx processor status register P: ALU flag writeback, SEx/CLx, PLP/RTI, interrupt entry.
// Define CPU65XX_CMOS_DCLR_EN to clear D on interrupt entry (65C02); default keeps D (NMOS).
module cpu65xx_status_reg
    import cpu65xx_status_reg_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h34,
    parameter bit         DELAY_I = 1'b1
) (
    input logic                  clk,
    input logic                  reset_n,
    cpu65xx_status_reg_if.slave  bus
);

    logic c_q, c_d;
    logic z_q, z_d;
    logic i_q, i_d;
    logic d_q, d_d;
    logic v_q, v_d;
    logic n_q, n_d;
    logic i_imm_wr;

    // Later assignments override earlier ones, giving the flag priority order.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        i_d = i_q;
        d_d = d_q;
        v_d = v_q;
        n_d = n_q;

        if (bus.flagWrite[0]) c_d = bus.aluCarry;
        if (bus.flagWrite[1]) z_d = bus.aluZero;
        if (bus.flagWrite[2]) v_d = bus.aluOverflow;
        if (bus.flagWrite[3]) n_d = bus.aluNegative;

        case (set_clr_op_e'(bus.setClrOp))
            SC_SEC:  c_d = 1'b1;
            SC_CLC:  c_d = 1'b0;
            SC_SED:  d_d = 1'b1;
            SC_CLD:  d_d = 1'b0;
            SC_SEI:  i_d = 1'b1;
            SC_CLI:  i_d = 1'b0;
            SC_CLV:  v_d = 1'b0;
            default: ;
        endcase

        if (bus.loadP) begin
            c_d = bus.dataIn[C_BIT_IN_P];
            z_d = bus.dataIn[Z_BIT_IN_P];
            i_d = bus.dataIn[I_BIT_IN_P];
            d_d = bus.dataIn[D_BIT_IN_P];
            v_d = bus.dataIn[V_BIT_IN_P];
            n_d = bus.dataIn[N_BIT_IN_P];
        end

        if (bus.interruptEntry) begin
            i_d = 1'b1;
`ifdef CPU65XX_CMOS_DCLR_EN
            d_d = 1'b0;
`else
            d_d = d_d;
`endif
        end

        i_imm_wr = bus.interruptEntry | (bus.loadP & bus.loadIsRti);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_q <= RESET_P[C_BIT_IN_P];
            z_q <= RESET_P[Z_BIT_IN_P];
            i_q <= RESET_P[I_BIT_IN_P];
            d_q <= RESET_P[D_BIT_IN_P];
            v_q <= RESET_P[V_BIT_IN_P];
            n_q <= RESET_P[N_BIT_IN_P];
        end else begin
            c_q <= c_d;
            z_q <= z_d;
            i_q <= i_d;
            d_q <= d_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    cpu65xx_imask_delay #(
        .DELAY_I (DELAY_I),
        .RESET_I (RESET_P[I_BIT_IN_P])
    ) u_imask_delay (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_next         (i_d),
        .i_imm_wr       (i_imm_wr),
        .instr_boundary (bus.instrBoundary),
        .irq_mask       (bus.irqMask)
    );

    assign bus.pFlags       = pack_p(n_q, v_q, 1'b1, d_q, i_q, z_q, c_q);
    assign bus.pushValue    = pack_p(n_q, v_q, bus.pushIsBrk, d_q, i_q, z_q, c_q);
    assign bus.carryFlag    = c_q;
    assign bus.overflowFlag = v_q;
    assign bus.decimalFlag  = d_q;

endmodule

// File: tb/tb_cpu65xx_status_reg.sv
// Directed bench for cpu65xx_status_reg: vector table for flag updates, plus I-mask sequences.
module tb_cpu65xx_status_reg;
    import cpu65xx_status_reg_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    cpu65xx_status_reg_if bus();

    cpu65xx_status_reg #(.RESET_P(8'h34), .DELAY_I(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CPU65XX_CMOS_DCLR_EN
    localparam logic [7:0] IE_P = 8'h34;
`else
    localparam logic [7:0] IE_P = 8'h3C;
`endif

    typedef struct {
        logic [3:0] fw;
        logic [3:0] alu;   // {N,V,Z,C}
        logic [2:0] sc;
        logic       ld;
        logic       rti;
        logic [7:0] din;
        logic       ie;
        logic       brk;
        logic       ib;
        logic [7:0] exp_p;
        logic       exp_m;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.flagWrite      = v.fw;
        bus.aluNegative    = v.alu[3];
        bus.aluOverflow    = v.alu[2];
        bus.aluZero        = v.alu[1];
        bus.aluCarry       = v.alu[0];
        bus.setClrOp       = v.sc;
        bus.loadP          = v.ld;
        bus.loadIsRti      = v.rti;
        bus.dataIn         = v.din;
        bus.interruptEntry = v.ie;
        bus.pushIsBrk      = v.brk;
        bus.instrBoundary  = v.ib;
    endtask

    task automatic idle();
        bus.flagWrite = 4'd0; bus.aluNegative = 1'b0; bus.aluOverflow = 1'b0;
        bus.aluZero = 1'b0; bus.aluCarry = 1'b0; bus.setClrOp = SC_NONE;
        bus.loadP = 1'b0; bus.loadIsRti = 1'b0; bus.dataIn = 8'h00;
        bus.interruptEntry = 1'b0; bus.pushIsBrk = 1'b0; bus.instrBoundary = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle microcode op then back to idle, checked after the edge.
    task automatic op(input logic [2:0] sc, input logic ld, input logic rti,
                      input logic [7:0] din, input logic ib);
        idle();
        bus.setClrOp = sc; bus.loadP = ld; bus.loadIsRti = rti;
        bus.dataIn = din; bus.instrBoundary = ib;
        step();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            fw       alu      sc      ld rti din    ie brk ib exp_p  m
        vecs[0]  = '{4'b0011, 4'b1111, SC_NONE, 0, 0, 8'h00, 0, 0, 0, 8'h37, 1};
        vecs[1]  = '{4'b0011, 4'b1111, SC_CLC,  0, 0, 8'h00, 0, 0, 0, 8'h36, 1};
        vecs[2]  = '{4'b1100, 4'b1111, SC_CLV,  0, 0, 8'h00, 0, 0, 0, 8'hB6, 1};
        vecs[3]  = '{4'b1111, 4'b0100, SC_NONE, 0, 0, 8'h00, 0, 0, 0, 8'h74, 1};
        vecs[4]  = '{4'b0000, 4'b0000, SC_SED,  0, 0, 8'h00, 0, 0, 0, 8'h7C, 1};
        vecs[5]  = '{4'b0000, 4'b0000, SC_CLD,  0, 0, 8'h00, 0, 0, 0, 8'h74, 1};
        vecs[6]  = '{4'b0000, 4'b0000, SC_SEC,  0, 0, 8'h00, 0, 0, 0, 8'h75, 1};
        vecs[7]  = '{4'b0000, 4'b0000, SC_NONE, 1, 1, 8'h00, 0, 0, 0, 8'h30, 0};
        vecs[8]  = '{4'b0000, 4'b0000, SC_NONE, 1, 0, 8'hFF, 0, 0, 0, 8'hFF, 0};
        vecs[9]  = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 0};
        vecs[10] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 1};
        vecs[11] = '{4'b0000, 4'b0000, SC_NONE, 1, 0, 8'hC3, 0, 1, 0, 8'hF3, 1};
        vecs[12] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 0, 8'hF3, 1};
        vecs[13] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'hF3, 1};
        vecs[14] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'hF3, 0};
        vecs[15] = '{4'b0000, 4'b0000, SC_NONE, 1, 0, 8'h08, 1, 0, 0, IE_P,  1};
        vecs[16] = '{4'b0000, 4'b0000, SC_NONE, 1, 0, 8'h08, 0, 0, 0, 8'h38, 1};
        vecs[17] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'h38, 1};
        vecs[18] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 0, 0, 1, 8'h38, 0};
        vecs[19] = '{4'b0000, 4'b0000, SC_NONE, 0, 0, 8'h00, 1, 0, 0, IE_P,  1};

        idle();
        reset_n = 1'b0;
        #23;
        chk("reset pFlags", bus.pFlags, 8'h34);
        chk("reset irqMask", {7'd0, bus.irqMask}, 8'h01);
        chk("reset decimalFlag", {7'd0, bus.decimalFlag}, 8'h00);
        chk("reset carryFlag", {7'd0, bus.carryFlag}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("vec%0d pFlags", i), bus.pFlags, vecs[i].exp_p);
            chk($sformatf("vec%0d irqMask", i), {7'd0, bus.irqMask}, {7'd0, vecs[i].exp_m});
            chk($sformatf("vec%0d pushValue", i), bus.pushValue,
                {vecs[i].exp_p[7:5], vecs[i].brk, vecs[i].exp_p[3:0]});
            chk($sformatf("vec%0d alu feedback", i),
                {5'd0, bus.decimalFlag, bus.overflowFlag, bus.carryFlag},
                {5'd0, vecs[i].exp_p[3], vecs[i].exp_p[6], vecs[i].exp_p[0]});
        end
        idle();

        // SEI, boundary, CLI, then three more boundaries.
        op(SC_NONE, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("rti clear mask", {7'd0, bus.irqMask}, 8'h00);
        op(SC_SEI, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("sei pFlags", bus.pFlags, 8'h34);
        chk("sei mask before B1", {7'd0, bus.irqMask}, 8'h00);
        op(SC_NONE, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("sei mask after B1", {7'd0, bus.irqMask}, 8'h00);
        op(SC_CLI, 1'b0, 1'b0, 8'h00, 1'b0);
        op(SC_NONE, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("cli mask after B2", {7'd0, bus.irqMask}, 8'h01);
        op(SC_NONE, 1'b0, 1'b0, 8'h00, 1'b1);
        op(SC_NONE, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("cli mask after B4", {7'd0, bus.irqMask}, 8'h00);

        // SEI coincident with a boundary, then a long gap with no boundary.
        op(SC_SEI, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("sei+boundary mask", {7'd0, bus.irqMask}, 8'h00);
        for (int k = 0; k < 5; k++) step();
        chk("no boundary mask holds", {7'd0, bus.irqMask}, 8'h00);
        op(SC_NONE, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("sei+boundary next mask", {7'd0, bus.irqMask}, 8'h01);

        // Asynchronous reset mid-run, checked between clock edges.
        op(SC_NONE, 1'b1, 1'b1, 8'hCB, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset pFlags", bus.pFlags, 8'h34);
        chk("async reset irqMask", {7'd0, bus.irqMask}, 8'h01);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu65xx_status_reg.md
Name: cpu65xx_status_reg

Overview:
Processor status register (P) for the 65xx core. It is the consumer end of the ALU flag interface: it latches ALU carry, zero, negative and overflow under microcode write-enables, and applies SEx/CLx, PLP/RTI loads and interrupt entry. It feeds carry, overflow and decimal back to the ALU and supplies the push byte for PHP/BRK/IRQ. It also owns the 6502 one-instruction delay on I-flag changes that the interrupt sampler uses.

Parameters:
RESET_P, 8'h34, stored-flag value after reset; bits 5/4 ignored (I=1, D=0 for NMOS).
DELAY_I, 1, 1 = CLI/SEI/PLP affect irqMask one instruction late; 0 = immediate.

Ports:
clk  in  1  core clock
reset_n  in  1  async active-low reset
aluCarry  in  1  ALU carry out
aluZero  in  1  ALU zero
aluNegative  in  1  ALU negative
aluOverflow  in  1  ALU overflow out
flagWrite  in  4  per-flag write enable: [0]=C [1]=Z [2]=V [3]=N
setClrOp  in  3  0 none, 1 SEC, 2 CLC, 3 SED, 4 CLD, 5 SEI, 6 CLI, 7 CLV
loadP  in  1  load flags from dataIn (PLP or RTI)
loadIsRti  in  1  qualifies loadP: 1 = RTI (immediate I), 0 = PLP (delayed I)
dataIn  in  8  pulled status byte
interruptEntry  in  1  IRQ/NMI/BRK vector cycle: set I
pushIsBrk  in  1  selects B=1 in pushValue
instrBoundary  in  1  one-cycle pulse on each opcode fetch
pFlags  out  8  {N,V,1,1,D,I,Z,C}
pushValue  out  8  {N,V,1,pushIsBrk,D,I,Z,C}
carryFlag  out  1  to ALU carryIn
overflowFlag  out  1  to ALU overflowIn
decimalFlag  out  1  to ALU decimalMode
irqMask  out  1  effective I for IRQ sampling

Behaviour:
- Reset (async, reset_n=0): C,Z,I,D,V,N take RESET_P bits. The internal stage register and irqMask both equal RESET_P[2]. Outputs are valid during reset.
- All updates are registered on the rising clk edge. Outputs are direct register views with no combinational input-to-output paths, except pushValue[4] = pushIsBrk.
- Per-bit priority, highest first: interruptEntry (I, and D when the option is on) > loadP > setClrOp > flagWrite > hold.
- flagWrite: each enabled bit copies its ALU input. Bits not enabled hold.
- setClrOp sets or clears only its target flag. If flagWrite targets the same bit in the same cycle, setClrOp wins (for example, CLV while flagWrite[2]=1 gives V=0).
- loadP: C,Z,I,D,V,N <= dataIn[0,1,2,3,6,7]. dataIn[5:4] are discarded.
- I-mask pipeline (DELAY_I=1): uses an internal iStage register.
  - On instrBoundary: irqMask <= iStage, then iStage <= I as it stands after this edge's update.
  - SEI, CLI and PLP change I only; irqMask follows at the second boundary after the change.
  - RTI load, interruptEntry and reset write I, iStage and irqMask in the same edge.
- instrBoundary coincident with SEI/CLI/PLP: iStage takes the new I value.
- DELAY_I=0: irqMask tracks I exactly, same edge.
- Simultaneous loadP and interruptEntry: I=1. All other bits come from dataIn.
- Stuck or never-asserted instrBoundary: irqMask holds; no timeout.

Optional Feature:
CPU65XX_CMOS_DCLR_EN
- Defined: interruptEntry also clears D in the same edge (65C02 behaviour).
- Undefined: interruptEntry leaves D unchanged (NMOS behaviour).

Decomposition:
- Shared constants: flag bit positions (C/Z/I/D/B/V/N_BIT_IN_P) and setClrOp encodings go in the existing 65xx microcode constants include, shared with the ALU and microcode ROM generator.
- One natural sub-module, cpu65xx_imask_delay: iStage/irqMask pipeline with immediate-write override, parameterised by DELAY_I.

Test Plan:
- Reset: assert reset_n=0 with RESET_P=8'h34 -> pFlags=8'h34, irqMask=1, decimalFlag=0, carryFlag=0.
- ALU writeback: aluCarry=1, aluZero=1, aluNegative=1, aluOverflow=1 with flagWrite=4'b0011 -> C=1, Z=1, V and N unchanged; repeat with CLC on the same cycle -> C=0.
- Load and push:
  - PLP with dataIn=8'hFF -> pFlags=8'hFF, irqMask still 0 until the second instrBoundary.
  - RTI with dataIn=8'h00 -> pFlags=8'h30, irqMask=0 on the same edge.
- I delay: with I=0, SEI then boundary pulses B1, B2 -> irqMask 0 after B1, 1 after B2; a CLI right after B1 leaves irqMask=1 after B2 and 0 after B4.
- Push byte: P=8'hC3, pushIsBrk=1 -> pushValue=8'hF3; pushIsBrk=0 -> 8'hE3.
- Interrupt entry with D=1: with CPU65XX_CMOS_DCLR_EN defined -> I=1, D=0, irqMask=1 on the same edge; without the macro -> D stays 1.
